ifu: RTL and testbench

//   Instruction fetch unit; sits between pcu and idu. Accepts a fetch PC, reads one
//   64-bit word from instruction memory over a valid/ready request + valid response
//   bus, selects the 32-bit instruction and holds it for idu under a valid/ready

---
 rtl/ifu.sv | 113 +++++++++++
 tb/tb_ifu.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: takes one PC from pcu, reads the enclosing 64-bit word from
// instruction memory, selects the addressed 32-bit instruction and holds it for idu.
module ifu #(
  parameter int unsigned CPU_WIDTH = 64,
  parameter int unsigned INS_WIDTH = 32,
  parameter int unsigned BUS_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pc_valid,
  output logic                 pc_ready,
  input  logic [CPU_WIDTH-1:0] pc,
  input  logic                 flush,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [CPU_WIDTH-1:0] mem_req_addr,
  input  logic                 mem_rsp_valid,
  input  logic [BUS_WIDTH-1:0] mem_rsp_data,
  input  logic                 mem_rsp_err,
  output logic                 ins_valid,
  input  logic                 ins_ready,
  output logic [INS_WIDTH-1:0] ins,
  output logic [CPU_WIDTH-1:0] ins_pc,
  output logic                 ins_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e               state_q, state_d;
  logic [CPU_WIDTH-1:0] pc_q, pc_d;
  logic [INS_WIDTH-1:0] ins_q, ins_d;
  logic                 ins_err_q, ins_err_d;
  logic                 drop_q, drop_d;
  logic                 pc_fire;
  logic [INS_WIDTH-1:0] rsp_word;

  // Gated by rst so pcu never sees a handshake during the reset cycle.
  assign pc_ready = (state_q == StIdle) && !flush && !rst;
  assign pc_fire  = pc_valid && pc_ready;

  // pc[2] picks the upper or lower instruction of the 64-bit beat.
  assign rsp_word = pc_q[2] ? mem_rsp_data[2*INS_WIDTH-1:INS_WIDTH]
                            : mem_rsp_data[INS_WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ins_d     = ins_q;
    ins_err_d = ins_err_q;
    drop_d    = drop_q;
    case (state_q)
      StIdle: begin
        if (pc_fire) begin
          pc_d = pc;
          if (pc[1:0] != 2'b00) begin
            ins_d     = '0;
            ins_err_d = 1'b1;
            state_d   = StHold;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        // The request stays up even on flush; the response is dropped instead.
        if (flush) drop_d = 1'b1;
        if (mem_req_ready) state_d = StWait;
      end
      StWait: begin
        if (mem_rsp_valid) begin
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = StIdle;
          end else begin
            ins_d     = mem_rsp_err ? '0 : rsp_word;
            ins_err_d = mem_rsp_err;
            state_d   = StHold;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      StHold: begin
        if (flush || ins_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      ins_q     <= '0;
      ins_err_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ins_q     <= ins_d;
      ins_err_q <= ins_err_d;
      drop_q    <= drop_d;
    end
  end

  assign mem_req_valid = (state_q == StReq);
  assign mem_req_addr  = {pc_q[CPU_WIDTH-1:3], 3'b000};
  assign ins_valid     = (state_q == StHold);
  assign ins           = ins_q;
  assign ins_pc        = pc_q;
  assign ins_err       = ins_err_q;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: table of single fetches plus hand-written flush/reset sequences.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_valid;
  logic        pc_ready;
  logic [63:0] pc;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic [63:0] ins_pc;
  logic        ins_err;

  always #5 clk = ~clk;

  ifu #(
    .CPU_WIDTH(64),
    .INS_WIDTH(32),
    .BUS_WIDTH(64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_valid     (pc_valid),
    .pc_ready     (pc_ready),
    .pc           (pc),
    .flush        (flush),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .mem_rsp_err  (mem_rsp_err),
    .ins_valid    (ins_valid),
    .ins_ready    (ins_ready),
    .ins          (ins),
    .ins_pc       (ins_pc),
    .ins_err      (ins_err)
  );

  typedef struct {
    logic [63:0] pc;
    int          req_wait;  // cycles mem_req_ready held low
    logic [63:0] data;
    logic        err;
    int          hold;      // cycles ins_ready held low
    bit          mem;       // expect a memory access
    logic [63:0] addr;
    logic [31:0] exp_ins;
    logic        exp_err;
  } vec_t;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch starting from IDLE; every check sits at a fixed cycle offset.
  task automatic fetch(input vec_t v);
    pc_valid = 1'b1;
    pc       = v.pc;
    #1;
    check("pc_ready_idle", pc_ready, 1);
    step();
    pc_valid = 1'b0;
    if (!v.mem) begin
      check("no_mem_req", mem_req_valid, 0);
    end else begin
      check("req_valid", mem_req_valid, 1);
      check("req_addr", mem_req_addr, v.addr);
      check("req_no_ins", ins_valid, 0);
      for (int i = 0; i < v.req_wait; i++) begin
        step();
        check("req_held", mem_req_valid, 1);
        check("req_addr_stable", mem_req_addr, v.addr);
      end
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      check("no_dup_req", mem_req_valid, 0);
      check("wait_no_ins", ins_valid, 0);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = v.data;
      mem_rsp_err   = v.err;
      step();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      mem_rsp_err   = 1'b0;
    end
    check("ins_valid", ins_valid, 1);
    check("ins", ins, v.exp_ins);
    check("ins_pc", ins_pc, v.pc);
    check("ins_err", ins_err, v.exp_err);
    for (int i = 0; i < v.hold; i++) begin
      step();
      check("hold_valid", ins_valid, 1);
      check("hold_ins", ins, v.exp_ins);
      check("hold_no_req", mem_req_valid, 0);
    end
    ins_ready = 1'b1;
    step();
    ins_ready = 1'b0;
    #1;
    check("ins_consumed", ins_valid, 0);
    check("pc_ready_after", pc_ready, 1);
  endtask

  vec_t vecs[6];
  vec_t hv;

  initial begin
    vecs[0] = '{pc: 64'h8000_0000, req_wait: 0, data: 64'h0000_0073_0010_0093, err: 0,
                hold: 0, mem: 1, addr: 64'h8000_0000, exp_ins: 32'h0010_0093, exp_err: 0};
    vecs[1] = '{pc: 64'h8000_0004, req_wait: 0, data: 64'h0000_0073_0010_0093, err: 0,
                hold: 0, mem: 1, addr: 64'h8000_0000, exp_ins: 32'h0000_0073, exp_err: 0};
    vecs[2] = '{pc: 64'h8000_0008, req_wait: 4, data: 64'h1234_5678_9abc_def0, err: 0,
                hold: 3, mem: 1, addr: 64'h8000_0008, exp_ins: 32'h9abc_def0, exp_err: 0};
    vecs[3] = '{pc: 64'h8000_0002, req_wait: 0, data: 64'h0, err: 0,
                hold: 1, mem: 0, addr: 64'h0, exp_ins: 32'h0, exp_err: 1};
    vecs[4] = '{pc: 64'h8000_000c, req_wait: 1, data: 64'hffff_ffff_ffff_ffff, err: 1,
                hold: 0, mem: 1, addr: 64'h8000_0008, exp_ins: 32'h0, exp_err: 1};
    vecs[5] = '{pc: 64'h8000_0014, req_wait: 0, data: 64'ha5a5_0000_1111_2222, err: 0,
                hold: 2, mem: 1, addr: 64'h8000_0010, exp_ins: 32'ha5a5_0000, exp_err: 0};

    rst           = 1'b1;
    pc_valid      = 1'b0;
    pc            = '0;
    flush         = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_err   = 1'b0;
    ins_ready     = 1'b0;
    step();
    step();
    check("rst_pc_ready", pc_ready, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_req_addr", mem_req_addr, 0);
    check("rst_ins_valid", ins_valid, 0);
    check("rst_ins", ins, 0);
    check("rst_ins_pc", ins_pc, 0);
    check("rst_ins_err", ins_err, 0);
    rst = 1'b0;
    #1;
    check("post_rst_pc_ready", pc_ready, 1);

    for (int i = 0; i < 6; i++) fetch(vecs[i]);

    // Flush in WAIT, response two cycles later must be discarded.
    pc_valid = 1'b1;
    pc       = 64'h8000_0040;
    step();
    pc_valid      = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    flush         = 1'b1;
    step();
    flush = 1'b0;
    #1;
    check("wflush_no_ins", ins_valid, 0);
    check("wflush_still_wait", pc_ready, 0);
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'hdead_beef_dead_beef;
    step();
    mem_rsp_valid = 1'b0;
    #1;
    check("wflush_discard", ins_valid, 0);
    check("wflush_idle", pc_ready, 1);
    hv = '{pc: 64'h8000_0100, req_wait: 0, data: 64'h0bad_f00d_0000_0013, err: 0,
           hold: 0, mem: 1, addr: 64'h8000_0100, exp_ins: 32'h0000_0013, exp_err: 0};
    fetch(hv);

    // Flush in REQ while stalled: request held, response dropped.
    pc_valid = 1'b1;
    pc       = 64'h8000_0204;
    step();
    pc_valid = 1'b0;
    flush    = 1'b1;
    #1;
    check("rflush_req_kept", mem_req_valid, 1);
    step();
    flush = 1'b0;
    check("rflush_req_still", mem_req_valid, 1);
    check("rflush_addr", mem_req_addr, 64'h8000_0200);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h1111_1111_2222_2222;
    step();
    mem_rsp_valid = 1'b0;
    #1;
    check("rflush_discard", ins_valid, 0);
    check("rflush_idle", pc_ready, 1);

    // Flush together with pc_valid in IDLE, plus a stray response: nothing happens.
    pc_valid      = 1'b1;
    pc            = 64'h8000_0300;
    flush         = 1'b1;
    mem_rsp_valid = 1'b1;
    #1;
    check("iflush_pc_ready", pc_ready, 0);
    step();
    pc_valid      = 1'b0;
    flush         = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    check("iflush_no_req", mem_req_valid, 0);
    check("iflush_no_ins", ins_valid, 0);
    check("iflush_idle", pc_ready, 1);

    // Flush in HOLD wins over ins_ready.
    pc_valid = 1'b1;
    pc       = 64'h8000_0302;
    step();
    pc_valid = 1'b0;
    check("hflush_hold", ins_valid, 1);
    flush     = 1'b1;
    ins_ready = 1'b1;
    step();
    flush     = 1'b0;
    ins_ready = 1'b0;
    #1;
    check("hflush_dropped", ins_valid, 0);
    check("hflush_idle", pc_ready, 1);

    // Reset while holding a valid instruction.
    pc_valid = 1'b1;
    pc       = 64'h8000_0404;
    step();
    pc_valid      = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h1111_2222_3333_4444;
    step();
    mem_rsp_valid = 1'b0;
    check("prerst_ins", ins, 32'h1111_2222);
    check("prerst_valid", ins_valid, 1);
    rst = 1'b1;
    step();
    check("hrst_ins_valid", ins_valid, 0);
    check("hrst_ins", ins, 0);
    check("hrst_ins_pc", ins_pc, 0);
    check("hrst_ins_err", ins_err, 0);
    check("hrst_req_valid", mem_req_valid, 0);
    check("hrst_req_addr", mem_req_addr, 0);
    check("hrst_pc_ready", pc_ready, 0);
    rst = 1'b0;
    #1;
    check("hrst_pc_ready_after", pc_ready, 1);
    fetch(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
